// File: rtl/multicycle_control_unit.sv
// Control FSM for a multicycle ARM-subset datapath: sequences fetch, decode, memory,
// ALU and branch steps, evaluates condition codes and holds the NZCV flags.
module multicycle_control_unit #(
  parameter int unsigned USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic [5:0] funct,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_write,
  output logic       reg_write,
  output logic       adr_src,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] result_src,
  output logic [1:0] imm_src,
  output logic [1:0] reg_src,
  output logic [2:0] alu_control,
  output logic [3:0] flags,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StAluWb    = 4'd8,
    StBranch   = 4'd9
  } state_e;

  typedef enum logic [2:0] {
    AluAdd = 3'b000,
    AluSub = 3'b001,
    AluAnd = 3'b010,
    AluOrr = 3'b011,
    AluMov = 3'b100
  } alu_op_e;

  state_e     state_q, state_d;
  logic [3:0] flags_q, flags_d;

  logic [3:0] cmd;
  logic       imm_bit;
  logic       s_bit;
  logic       mem_done;
  logic       rd_is_pc;

  assign imm_bit  = funct[5];
  assign cmd      = funct[4:1];
  assign s_bit    = funct[0];
  assign mem_done = (USE_MEM_READY == 0) || mem_ready;
  assign rd_is_pc = (rd == 4'hf);

  // Data-processing command decode.
  logic    cmd_ok;
  logic    cmd_is_cmp;
  logic    cmd_arith;
  alu_op_e cmd_alu;

  always_comb begin
    cmd_ok     = 1'b1;
    cmd_is_cmp = 1'b0;
    cmd_arith  = 1'b0;
    cmd_alu    = AluAdd;
    case (cmd)
      4'b0100: begin cmd_alu = AluAdd; cmd_arith = 1'b1; end
      4'b0010: begin cmd_alu = AluSub; cmd_arith = 1'b1; end
      4'b0000: cmd_alu = AluAnd;
      4'b1100: cmd_alu = AluOrr;
      4'b1101: cmd_alu = AluMov;
      4'b1010: begin cmd_alu = AluSub; cmd_arith = 1'b1; cmd_is_cmp = 1'b1; end
      default: cmd_ok = 1'b0;
    endcase
  end

  // Condition evaluation against the registered flags.
  logic flag_n, flag_z, flag_c, flag_v;
  logic cond_pass;

  assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

  always_comb begin
    cond_pass = 1'b0;
    case (cond)
      4'b0000: cond_pass = flag_z;
      4'b0001: cond_pass = !flag_z;
      4'b0010: cond_pass = flag_c;
      4'b0011: cond_pass = !flag_c;
      4'b0100: cond_pass = flag_n;
      4'b0101: cond_pass = !flag_n;
      4'b0110: cond_pass = flag_v;
      4'b0111: cond_pass = !flag_v;
      4'b1000: cond_pass = flag_c && !flag_z;
      4'b1001: cond_pass = !flag_c || flag_z;
      4'b1010: cond_pass = (flag_n == flag_v);
      4'b1011: cond_pass = (flag_n != flag_v);
      4'b1100: cond_pass = !flag_z && (flag_n == flag_v);
      4'b1101: cond_pass = flag_z || (flag_n != flag_v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFetch;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flags_d     = flags_q;
    pc_write    = 1'b0;
    ir_write    = 1'b0;
    mem_write   = 1'b0;
    reg_write   = 1'b0;
    adr_src     = 1'b0;
    alu_src_a   = 1'b0;
    alu_src_b   = 2'b00;
    result_src  = 2'b00;
    alu_control = AluAdd;
    illegal     = 1'b0;
    imm_src     = op;
    reg_src     = {op == 2'b01, op == 2'b10};

    case (state_q)
      StFetch: begin
        alu_src_a  = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = StDecode;
        end
      end
      StDecode: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_d   = StFetch;
        if (cond_pass) begin
          case (op)
            2'b01: state_d = StMemAdr;
            2'b10: state_d = StBranch;
            2'b00: begin
              if (!cmd_ok) illegal = 1'b1;
              else         state_d = imm_bit ? StExecI : StExecR;
            end
            default: illegal = 1'b1;
          endcase
        end
      end
      StMemAdr: begin
        alu_src_b = 2'b01;
        state_d   = s_bit ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        adr_src = 1'b1;
        if (mem_done) state_d = StMemWb;
      end
      StMemWb: begin
        result_src = 2'b01;
        pc_write   = rd_is_pc;
        reg_write  = !rd_is_pc;
        state_d    = StFetch;
      end
      StMemWrite: begin
        adr_src   = 1'b1;
        mem_write = 1'b1;
        if (mem_done) state_d = StFetch;
      end
      StExecR: begin
        alu_control = cmd_alu;
        state_d     = StAluWb;
      end
      StExecI: begin
        alu_src_b   = 2'b01;
        alu_control = cmd_alu;
        state_d     = StAluWb;
      end
      StAluWb: begin
        alu_control = cmd_alu;
        // CMP has no writeback, so a destination of r15 does not redirect the PC.
        pc_write    = !cmd_is_cmp && rd_is_pc;
        reg_write   = !cmd_is_cmp && !rd_is_pc;
        if (s_bit || cmd_is_cmp) begin
          flags_d[3:2] = alu_flags[3:2];
          if (cmd_arith) flags_d[1:0] = alu_flags[1:0];
        end
        state_d = StFetch;
      end
      StBranch: begin
        alu_src_b  = 2'b01;
        result_src = 2'b10;
        pc_write   = 1'b1;
        state_d    = StFetch;
      end
      default: state_d = StFetch;
    endcase

    // Reset overrides outputs combinationally so nothing is enabled while rst_n is low.
    if (!rst_n) begin
      pc_write    = 1'b0;
      ir_write    = 1'b0;
      mem_write   = 1'b0;
      reg_write   = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 1'b1;
      alu_src_b   = 2'b10;
      result_src  = 2'b10;
      alu_control = AluAdd;
      illegal     = 1'b0;
      imm_src     = 2'b00;
      reg_src     = 2'b00;
    end
  end

  assign flags = flags_q;
  assign state = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Bench for multicycle_control_unit: per-instruction expected cycle traces built from the
// architectural rules, plus directed cases and a mid-store reset.
module tb_multicycle_control_unit;

  localparam int SFetch = 0, SDecode = 1, SMemAdr = 2, SMemRead = 3, SMemWb = 4;
  localparam int SMemWrite = 5, SExecR = 6, SExecI = 7, SAluWb = 8, SBranch = 9;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] cond;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] rd;
  logic [3:0] alu_flags;
  logic       mem_ready;
  logic       pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a;
  logic [1:0] alu_src_b, result_src, imm_src, reg_src;
  logic [2:0] alu_control;
  logic [3:0] flags;
  logic       illegal;
  logic [3:0] state;

  multicycle_control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cond        (cond),
    .op          (op),
    .funct       (funct),
    .rd          (rd),
    .alu_flags   (alu_flags),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .ir_write    (ir_write),
    .mem_write   (mem_write),
    .reg_write   (reg_write),
    .adr_src     (adr_src),
    .alu_src_a   (alu_src_a),
    .alu_src_b   (alu_src_b),
    .result_src  (result_src),
    .imm_src     (imm_src),
    .reg_src     (reg_src),
    .alu_control (alu_control),
    .flags       (flags),
    .illegal     (illegal),
    .state       (state)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         st;
    logic       mr;
    logic [13:0] ctl;
    logic [3:0] fl;
  } cyc_t;

  cyc_t       trace[$];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] model_flags = 4'b0000;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Control word: ir_write pc_write reg_write mem_write adr_src alu_src_a
  // alu_src_b[1:0] result_src[1:0] alu_control[2:0] illegal.
  function automatic logic [13:0] mk_ctl(input logic irw, input logic pcw, input logic rw,
                                         input logic mw, input logic adr, input logic sa,
                                         input logic [1:0] sb, input logic [1:0] rs,
                                         input logic [2:0] ac, input logic ill);
    return {irw, pcw, rw, mw, adr, sa, sb, rs, ac, ill};
  endfunction

  function automatic logic cond_true(input logic [3:0] cc, input logic [3:0] f);
    logic n, z, c, v;
    {n, z, c, v} = f;
    case (cc)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return c;
      4'd3:  return !c;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return c && !z;
      4'd9:  return !c || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic cmd_supported(input logic [3:0] cmd);
    return cmd inside {4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101, 4'b1010};
  endfunction

  function automatic logic [2:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010: return 3'b001;
      4'b0000:          return 3'b010;
      4'b1100:          return 3'b011;
      4'b1101:          return 3'b100;
      default:          return 3'b000;
    endcase
  endfunction

  task automatic push(input int st, input logic mr, input logic [13:0] ctl);
    cyc_t e;
    e.st  = st;
    e.mr  = mr;
    e.ctl = ctl;
    e.fl  = model_flags;
    trace.push_back(e);
  endtask

  task automatic run_instr(input logic [3:0] i_cond, input logic [1:0] i_op,
                           input logic [5:0] i_funct, input logic [3:0] i_rd,
                           input logic [3:0] af, input int fstall, input int mstall,
                           input bit rst_in_store);
    logic [3:0]  cmd;
    logic        pass, ill, cmp, pcdst;
    logic [2:0]  ac;
    logic [13:0] fetch_wait, mem_ctl;
    cmd   = i_funct[4:1];
    pass  = cond_true(i_cond, model_flags);
    ill   = pass && (i_op == 2'b11 || (i_op == 2'b00 && !cmd_supported(cmd)));
    pcdst = (i_rd == 4'hf);
    trace.delete();

    fetch_wait = mk_ctl(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 3'b000, 0);
    for (int i = 0; i < fstall; i++) push(SFetch, 1'b0, fetch_wait);
    push(SFetch, 1'b1, mk_ctl(1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 3'b000, 0));
    push(SDecode, 1'($urandom), mk_ctl(0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b000, ill));

    if (pass && !ill) begin
      case (i_op)
        2'b01: begin
          push(SMemAdr, 1'($urandom), mk_ctl(0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b000, 0));
          if (i_funct[0]) begin
            mem_ctl = mk_ctl(0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0);
            for (int i = 0; i < mstall; i++) push(SMemRead, 1'b0, mem_ctl);
            push(SMemRead, 1'b1, mem_ctl);
            push(SMemWb, 1'($urandom),
                 mk_ctl(0, pcdst, !pcdst, 0, 0, 0, 2'b00, 2'b01, 3'b000, 0));
          end else begin
            mem_ctl = mk_ctl(0, 0, 0, 1, 1, 0, 2'b00, 2'b00, 3'b000, 0);
            for (int i = 0; i < mstall; i++) push(SMemWrite, 1'b0, mem_ctl);
            push(SMemWrite, 1'b1, mem_ctl);
          end
        end
        2'b00: begin
          ac  = alu_of(cmd);
          cmp = (cmd == 4'b1010);
          push(i_funct[5] ? SExecI : SExecR, 1'($urandom),
               mk_ctl(0, 0, 0, 0, 0, 0, i_funct[5] ? 2'b01 : 2'b00, 2'b00, ac, 0));
          push(SAluWb, 1'($urandom),
               mk_ctl(0, !cmp && pcdst, !cmp && !pcdst, 0, 0, 0, 2'b00, 2'b00, ac, 0));
          if (i_funct[0] || cmp) begin
            model_flags[3:2] = af[3:2];
            if (cmd inside {4'b0100, 4'b0010, 4'b1010}) model_flags[1:0] = af[1:0];
          end
        end
        default: push(SBranch, 1'($urandom),
                      mk_ctl(0, 1, 0, 0, 0, 0, 2'b01, 2'b10, 3'b000, 0));
      endcase
    end

    foreach (trace[k]) begin
      @(negedge clk);
      if (k == 0) begin
        cond  = i_cond;
        op    = i_op;
        funct = i_funct;
        rd    = i_rd;
      end
      mem_ready = trace[k].mr;
      alu_flags = af;
      #1;
      check_eq("state", 32'(state), 32'(trace[k].st));
      check_eq("ctl", 32'({ir_write, pc_write, reg_write, mem_write, adr_src, alu_src_a,
                           alu_src_b, result_src, alu_control, illegal}), 32'(trace[k].ctl));
      check_eq("flags", 32'(flags), 32'(trace[k].fl));
      check_eq("imm_reg_src", 32'({imm_src, reg_src}),
               32'({i_op, i_op == 2'b01, i_op == 2'b10}));
      if (rst_in_store && trace[k].st == SMemWrite) begin
        #2;
        mem_ready = 1'b1;
        rst_n     = 1'b0;
        #1;
        check_eq("rst_mem_write", 32'(mem_write), 32'(0));
        check_eq("rst_state", 32'(state), 32'(SFetch));
        check_eq("rst_flags", 32'(flags), 32'(0));
        check_eq("rst_ctl", 32'({ir_write, pc_write, reg_write, mem_write, adr_src, alu_src_a,
                                 alu_src_b, result_src, alu_control, illegal}),
                 32'(mk_ctl(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 3'b000, 0)));
        model_flags = 4'b0000;
        mem_ready   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    logic [3:0] r_cmd, r_cond, r_rd;
    logic [1:0] r_op;
    logic [3:0] cmd_tab [6];
    cmd_tab = '{4'b0100, 4'b0010, 4'b0000, 4'b1100, 4'b1101, 4'b1010};

    rst_n     = 1'b0;
    cond      = 4'hf;
    op        = 2'b11;
    funct     = 6'b111111;
    rd        = 4'hf;
    alu_flags = 4'hf;
    mem_ready = 1'b1;
    #12;
    check_eq("reset_state", 32'(state), 32'(SFetch));
    check_eq("reset_flags", 32'(flags), 32'(0));
    check_eq("reset_ctl", 32'({ir_write, pc_write, reg_write, mem_write, adr_src, alu_src_a,
                               alu_src_b, result_src, alu_control, illegal}),
             32'(mk_ctl(0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 3'b000, 0)));
    check_eq("reset_imm_reg_src", 32'({imm_src, reg_src}), 32'(0));
    @(negedge clk);
    mem_ready = 1'b0;
    rst_n     = 1'b1;

    // ADD r0,r0,#4; CMP r1,#0xFF; LDR with two wait cycles.
    run_instr(4'he, 2'b00, 6'b101000, 4'd0, 4'b1111, 0, 0, 0);
    run_instr(4'he, 2'b00, 6'b110101, 4'd1, 4'b0110, 0, 0, 0);
    run_instr(4'he, 2'b01, 6'b011001, 4'd1, 4'b0000, 0, 2, 0);
    // BEQ taken (Z=1), clear flags, BEQ not taken.
    run_instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000, 1, 0, 0);
    run_instr(4'he, 2'b00, 6'b110101, 4'd0, 4'b0000, 0, 0, 0);
    run_instr(4'h0, 2'b10, 6'b100000, 4'd0, 4'b0000, 0, 0, 0);
    // Set flags nonzero, then reset in the middle of a stalled store.
    run_instr(4'he, 2'b00, 6'b110101, 4'd0, 4'b1011, 0, 0, 0);
    run_instr(4'he, 2'b01, 6'b011000, 4'd2, 4'b0000, 0, 2, 1);
    // op=11 is illegal.
    run_instr(4'he, 2'b11, 6'b000000, 4'd3, 4'b0000, 0, 0, 0);

    for (int n = 0; n < 300; n++) begin
      r_cmd  = ($urandom_range(3) == 0) ? 4'($urandom) : cmd_tab[$urandom_range(5)];
      r_cond = ($urandom_range(1) == 0) ? 4'he : 4'($urandom);
      r_op   = ($urandom_range(7) == 0) ? 2'b11 : 2'($urandom_range(2));
      r_rd   = ($urandom_range(7) == 0) ? 4'hf : 4'($urandom_range(14));
      run_instr(r_cond, r_op, {1'($urandom), r_cmd, 1'($urandom)}, r_rd, 4'($urandom),
                $urandom_range(2), $urandom_range(2), 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control_unit.md
MULTICYCLE_CONTROL_UNIT -- requirements
Module: multicycle_control_unit

Interface
REQ-001 Parameter: USE_MEM_READY, default 1, meaning: 1 = memory states wait on mem_ready; 0 = memory always completes in one cycle and mem_ready is ignored.
REQ-002 Port: clk  in  1  the single clock; all state changes on its rising edge.
REQ-003 Port: rst_n  in  1  reset, asynchronous and active-low.
REQ-004 Port: cond  in  4  instruction condition field [31:28].
REQ-005 Port: op  in  2  instruction opcode field [27:26].
REQ-006 Port: funct  in  6  instruction field [25:20]: I, cmd[3:0], S/L.
REQ-007 Port: rd  in  4  destination register field.
REQ-008 Port: alu_flags  in  4  NZCV produced by the ALU in the current cycle.
REQ-009 Port: mem_ready  in  1  memory access complete.
REQ-010 Port: pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a  out  1 each  datapath enables and selects.
REQ-011 Port: alu_src_b, result_src, imm_src, reg_src  out  2 each  datapath selects.
REQ-012 Port: alu_control  out  3  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 MOV (pass B).
REQ-013 Port: flags  out  4  registered NZCV.
REQ-014 Port: illegal  out  1  one-cycle pulse on unsupported instruction.
REQ-015 Port: state  out  4  current FSM state, for debug.

Function
REQ-016 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BRANCH.
REQ-017 Outputs not listed for a state SHALL be 0.
REQ-018 FETCH: adr_src=0, alu_src_a=1, alu_src_b=10, ADD, result_src=10; ir_write=pc_write=1 only on completion (mem_ready=1 or USE_MEM_READY=0). Otherwise hold FETCH with both at 0.
REQ-019 DECODE: alu_src_a=1, alu_src_b=10, ADD; evaluate cond against registered flags.
  - cond false -> FETCH.
  - op=01 -> MEMADR.
  - op=00, I=1 -> EXECI.
  - op=00, I=0 -> EXECR.
  - op=10 -> BRANCH.
  - op=11 or unsupported cmd -> FETCH with illegal=1.
REQ-020 Conditions: full ARM set 0000..1101; 1110 = always; 1111 = never.
REQ-021 cmd mapping: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1101 MOV, 1010 CMP (SUB, no writeback, flags always update). Any other cmd is unsupported.
REQ-022 MEMADR: alu_src_b=01, ADD; funct[0]=1 -> MEMREAD, else -> MEMWRITE.
REQ-023 MEMREAD: adr_src=1; goes to MEMWB on completion, else holds.
REQ-024 MEMWB: result_src=01, reg_write=1 -> FETCH.
REQ-025 MEMWRITE: adr_src=1, mem_write=1 every cycle held; goes to FETCH on completion.
REQ-026 EXECR: alu_src_b=00. EXECI: alu_src_b=01. Both drive alu_control per cmd and go -> ALUWB.
REQ-027 ALUWB: result_src=00, alu_control held; reg_write=1 except CMP -> FETCH.
REQ-028 BRANCH: alu_src_b=01, ADD, result_src=10, pc_write=1 -> FETCH.
REQ-029 rd=15 in ALUWB or MEMWB: pc_write=1, reg_write=0.
REQ-030 imm_src equals op. reg_src[0]=(op==10). reg_src[1]=(op==01).
REQ-031 Flag update in ALUWB when S=1 or CMP:
  - NZ <= alu_flags[3:2].
  - CV <= alu_flags[1:0] only for ADD/SUB/CMP; otherwise CV is retained.
REQ-032 Instruction fields are sampled from the instruction register; they are stable from DECODE onward.

Reset
REQ-033 rst_n=0 forces state=FETCH and flags=0000 immediately, regardless of clk, including mid-instruction.
REQ-034 While in reset, all outputs are 0 except alu_src_a=1, alu_src_b=10, result_src=10. The first FETCH completes no earlier than the first edge after rst_n rises.

Verification
REQ-035 ADD r0,r0,#4 (cond E, op 00, funct 101000, rd 0), mem_ready=1 -> FETCH, DECODE, EXECI, ALUWB; reg_write=1 in cycle 4 only; alu_control=000; flags unchanged.
REQ-036 CMP r1,#0xFF (funct 110101) with alu_flags=0110 -> ALUWB has reg_write=0; flags=0110 after.
REQ-037 LDR r1,[r0] (op 01, funct 011001), mem_ready low 2 cycles in MEMREAD -> MEMREAD lasts 3 cycles, then MEMWB reg_write=1; total 7 cycles.
REQ-038 BEQ (cond 0000, op 10) with flags Z=0 -> FETCH, DECODE, FETCH; no pc_write after the fetch. With Z=1 -> BRANCH with pc_write=1.
REQ-039 STR with rst_n pulsed low during MEMWRITE -> mem_write drops immediately, state=FETCH, flags=0000.
REQ-040 op=11 -> illegal=1 for the single DECODE cycle, then FETCH; no reg_write or mem_write.
